aes_axil_regs: RTL and testbench

- AXI4-Lite slave (responder) register file fronting the AES-CTR core; the bus master side is the AXI VIP in simulation and the PS in hardware.
- Decodes 32-bit register writes and reads into key, block and config registers, single-cycle init/next command pulses, a status register, and a captured result.
- Sits between the interconnect and the AES core; contains no cryptographic logic.

---
 rtl/aes_axil_pkg.sv | 75 +++++++
 rtl/aes_axil_regs.sv | 236 +++++++++++++++++++++++
 tb/tb_aes_axil_regs.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_axil_pkg.sv
// Shared constants and decode helpers for the AES AXI4-Lite register file.
package aes_axil_pkg;

  localparam int ADDR_W_DEF = 7;

  localparam logic [31:0] OFF_CTRL    = 32'h00;
  localparam logic [31:0] OFF_CONFIG  = 32'h04;
  localparam logic [31:0] OFF_STATUS  = 32'h08;
  localparam logic [31:0] OFF_KEY0    = 32'h18;
  localparam logic [31:0] OFF_KEY7    = 32'h34;
  localparam logic [31:0] OFF_BLOCK0  = 32'h38;
  localparam logic [31:0] OFF_BLOCK3  = 32'h44;
  localparam logic [31:0] OFF_RESULT0 = 32'h48;
  localparam logic [31:0] OFF_RESULT3 = 32'h54;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_INIT    = 0;
  localparam int CTRL_NEXT    = 1;
  localparam int STAT_READY   = 0;
  localparam int STAT_VALID   = 1;
  localparam int STAT_DROPPED = 2;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_CONFIG,
    SEL_STATUS,
    SEL_KEY,
    SEL_BLOCK,
    SEL_RESULT,
    SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] idx;
  } reg_dec_t;

  // Word-aligned byte offset in, register group and word index within the group out.
  function automatic reg_dec_t decode_offset(input logic [31:0] off);
    reg_dec_t d;
    d.sel = SEL_NONE;
    d.idx = '0;
    if (off == OFF_CTRL) begin
      d.sel = SEL_CTRL;
    end else if (off == OFF_CONFIG) begin
      d.sel = SEL_CONFIG;
    end else if (off == OFF_STATUS) begin
      d.sel = SEL_STATUS;
    end else if (off >= OFF_KEY0 && off <= OFF_KEY7) begin
      d.sel = SEL_KEY;
      d.idx = off[4:2] - OFF_KEY0[4:2];
    end else if (off >= OFF_BLOCK0 && off <= OFF_BLOCK3) begin
      d.sel = SEL_BLOCK;
      d.idx = off[4:2] - OFF_BLOCK0[4:2];
    end else if (off >= OFF_RESULT0 && off <= OFF_RESULT3) begin
      d.sel = SEL_RESULT;
      d.idx = off[4:2] - OFF_RESULT0[4:2];
    end
    return d;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_axil_regs.sv
// AXI4-Lite register file in front of the AES-CTR core: key/block/config storage,
// init/next command pulses, status and captured result.
module aes_axil_regs
  import aes_axil_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              core_init,
  output logic              core_next,
  output logic              core_encdec,
  output logic              core_keylen,
  output logic [255:0]      core_key,
  output logic [127:0]      core_block,
  input  logic              core_ready,
  input  logic [127:0]      core_result,
  input  logic              core_result_valid
);

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Write channel state
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:2] aw_word;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              aw_ready;
  logic              w_ready;
  logic              commit;

  // Read channel state
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              ar_ready;
  logic              ar_hs;

  // Register storage
  logic [1:0]        config_q;
  logic [31:0]       key_q    [8];
  logic [31:0]       block_q  [4];
  logic [31:0]       result_q [4];
  logic              status_valid;
  logic              cmd_dropped;
  logic              init_q;
  logic              next_q;
  logic              rv_q;

  reg_dec_t          wdec;
  reg_dec_t          rdec;
  logic [1:0]        wr_resp;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic              ctrl_fire;
  logic              pulse_init;
  logic              pulse_next;
  logic              drop_evt;
  logic              capture;
  logic              status_rd;

  assign wdec = decode_offset({{(32-ADDR_W){1'b0}}, aw_word, 2'b00});
  assign rdec = decode_offset({{(32-ADDR_W){1'b0}}, s_axi_araddr[ADDR_W-1:2], 2'b00});

  // Ready stays low for the whole B phase so only one write is ever outstanding.
  assign aw_ready = aresetn & ~aw_held & ~bvalid_q;
  assign w_ready  = aresetn & ~w_held & ~bvalid_q;
  assign commit   = aw_held & w_held & ~bvalid_q;

  assign ar_ready = aresetn & ~rvalid_q;
  assign ar_hs    = s_axi_arvalid & ar_ready;

  always_comb begin
    wr_resp = RESP_SLVERR;
    case (wdec.sel)
      SEL_CTRL, SEL_CONFIG, SEL_KEY, SEL_BLOCK: wr_resp = RESP_OKAY;
      default:                                  wr_resp = RESP_SLVERR;
    endcase
  end

  assign ctrl_fire  = commit & (wdec.sel == SEL_CTRL) & w_strb[0]
                    & (w_data[CTRL_INIT] | w_data[CTRL_NEXT]);
  assign pulse_init = ctrl_fire & core_ready & w_data[CTRL_INIT];
  assign pulse_next = ctrl_fire & core_ready & ~w_data[CTRL_INIT] & w_data[CTRL_NEXT];
  assign drop_evt   = ctrl_fire & ~core_ready;
  assign capture    = core_result_valid & ~rv_q;
  assign status_rd  = ar_hs & (rdec.sel == SEL_STATUS);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_word  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && aw_ready) begin
        aw_held <= 1'b1;
        aw_word <= s_axi_awaddr[ADDR_W-1:2];
      end
      if (s_axi_wvalid && w_ready) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      config_q     <= '0;
      for (int i = 0; i < 8; i++) key_q[i] <= '0;
      for (int i = 0; i < 4; i++) block_q[i] <= '0;
      for (int i = 0; i < 4; i++) result_q[i] <= '0;
      status_valid <= 1'b0;
      cmd_dropped  <= 1'b0;
      init_q       <= 1'b0;
      next_q       <= 1'b0;
      rv_q         <= 1'b0;
    end else begin
      rv_q   <= core_result_valid;
      init_q <= pulse_init;
      next_q <= pulse_next;

      if (commit) begin
        case (wdec.sel)
          SEL_CONFIG: if (w_strb[0]) config_q <= w_data[1:0];
          SEL_KEY:    key_q[wdec.idx] <= apply_wstrb(key_q[wdec.idx], w_data, w_strb);
          SEL_BLOCK:  block_q[wdec.idx[1:0]] <= apply_wstrb(block_q[wdec.idx[1:0]], w_data, w_strb);
          default:    ;
        endcase
      end

      // A drop in the same cycle as a STATUS read must survive the read's clear.
      if (drop_evt) begin
        cmd_dropped <= 1'b1;
      end else if (status_rd) begin
        cmd_dropped <= 1'b0;
      end

      if (capture) begin
        result_q[0]  <= core_result[127:96];
        result_q[1]  <= core_result[95:64];
        result_q[2]  <= core_result[63:32];
        result_q[3]  <= core_result[31:0];
        status_valid <= 1'b1;
      end else if (init_q || next_q) begin
        status_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rdec.sel)
      SEL_CTRL:   rd_data = '0;
      SEL_CONFIG: rd_data = {30'b0, config_q};
      SEL_STATUS: begin
        rd_data[STAT_READY]   = core_ready;
        rd_data[STAT_VALID]   = status_valid;
        rd_data[STAT_DROPPED] = cmd_dropped;
      end
      SEL_KEY:    rd_data = key_q[rdec.idx];
      SEL_BLOCK:  rd_data = block_q[rdec.idx[1:0]];
      SEL_RESULT: rd_data = result_q[rdec.idx[1:0]];
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  // Read data is sampled at the AR handshake, so a same-cycle write commit is not visible.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi_awready = aw_ready;
  assign s_axi_wready  = w_ready;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ar_ready;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign core_init   = init_q;
  assign core_next   = next_q;
  assign core_encdec = config_q[0];
  assign core_keylen = config_q[1];
  assign core_key    = {key_q[0], key_q[1], key_q[2], key_q[3],
                        key_q[4], key_q[5], key_q[6], key_q[7]};
  assign core_block  = {block_q[0], block_q[1], block_q[2], block_q[3]};

endmodule

// File: tb/tb_aes_axil_regs.sv
// Randomized and directed bench for aes_axil_regs against a register-map model.
module tb_aes_axil_regs;

  logic         aclk;
  logic         aresetn;
  logic [6:0]   s_axi_awaddr;
  logic [2:0]   s_axi_awprot;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata;
  logic [3:0]   s_axi_wstrb;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [6:0]   s_axi_araddr;
  logic [2:0]   s_axi_arprot;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic         core_init;
  logic         core_next;
  logic         core_encdec;
  logic         core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;
  logic         core_result_valid;

  aes_axil_regs #(.ADDR_W(7)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axi_awaddr      (s_axi_awaddr),
    .s_axi_awprot      (s_axi_awprot),
    .s_axi_awvalid     (s_axi_awvalid),
    .s_axi_awready     (s_axi_awready),
    .s_axi_wdata       (s_axi_wdata),
    .s_axi_wstrb       (s_axi_wstrb),
    .s_axi_wvalid      (s_axi_wvalid),
    .s_axi_wready      (s_axi_wready),
    .s_axi_bresp       (s_axi_bresp),
    .s_axi_bvalid      (s_axi_bvalid),
    .s_axi_bready      (s_axi_bready),
    .s_axi_araddr      (s_axi_araddr),
    .s_axi_arprot      (s_axi_arprot),
    .s_axi_arvalid     (s_axi_arvalid),
    .s_axi_arready     (s_axi_arready),
    .s_axi_rdata       (s_axi_rdata),
    .s_axi_rresp       (s_axi_rresp),
    .s_axi_rvalid      (s_axi_rvalid),
    .s_axi_rready      (s_axi_rready),
    .core_init         (core_init),
    .core_next         (core_next),
    .core_encdec       (core_encdec),
    .core_keylen       (core_keylen),
    .core_key          (core_key),
    .core_block        (core_block),
    .core_ready        (core_ready),
    .core_result       (core_result),
    .core_result_valid (core_result_valid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int pulse_cyc = -1;
  bit pulse_is_init = 1'b0;
  int init_cnt = 0;
  int next_cnt = 0;

  // Register-map model
  logic [31:0] m_key [8];
  logic [31:0] m_block [4];
  logic [31:0] m_result [4];
  logic [1:0]  m_cfg;
  bit          m_valid;
  bit          m_dropped;

  always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: expected event did not occur within its cycle budget", name);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_key[i] = '0;
    for (int i = 0; i < 4; i++) m_block[i] = '0;
    for (int i = 0; i < 4; i++) m_result[i] = '0;
    m_cfg = '0;
    m_valid = 1'b0;
    m_dropped = 1'b0;
    pulse_cyc = -1;
  endtask

  task automatic m_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] r);
    int w;
    w = int'(a[6:2]);
    r = 2'b10;
    if (w == 0) begin
      r = 2'b00;
      if (s[0] && d[1:0] != 2'b00) begin
        if (core_ready) begin
          pulse_cyc = cyc_cnt;
          pulse_is_init = d[0];
          m_valid = 1'b0;
        end else begin
          m_dropped = 1'b1;
        end
      end
    end else if (w == 1) begin
      r = 2'b00;
      if (s[0]) m_cfg = d[1:0];
    end else if (w >= 6 && w <= 13) begin
      r = 2'b00;
      m_key[w-6] = merge(m_key[w-6], d, s);
    end else if (w >= 14 && w <= 17) begin
      r = 2'b00;
      m_block[w-14] = merge(m_block[w-14], d, s);
    end
  endtask

  task automatic m_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r);
    int w;
    w = int'(a[6:2]);
    d = '0;
    r = 2'b00;
    if (w == 0) d = '0;
    else if (w == 1) d = {30'b0, m_cfg};
    else if (w == 2) begin
      d = {29'b0, m_dropped, m_valid, core_ready};
      m_dropped = 1'b0;
    end
    else if (w >= 6 && w <= 13) d = m_key[w-6];
    else if (w >= 14 && w <= 17) d = m_block[w-14];
    else if (w >= 18 && w <= 21) d = m_result[w-18];
    else r = 2'b10;
  endtask

  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      check("core_key", core_key, {m_key[0], m_key[1], m_key[2], m_key[3],
                                   m_key[4], m_key[5], m_key[6], m_key[7]});
      check("core_block", core_block, {m_block[0], m_block[1], m_block[2], m_block[3]});
      check("core_encdec", core_encdec, m_cfg[0]);
      check("core_keylen", core_keylen, m_cfg[1]);
      check("core_init", core_init, (cyc_cnt == pulse_cyc) && pulse_is_init);
      check("core_next", core_next, (cyc_cnt == pulse_cyc) && !pulse_is_init);
      if (s_axi_bvalid) check("no_accept_during_b", {s_axi_awready, s_axi_wready}, 2'b00);
      if (s_axi_rvalid) check("no_ar_during_r", s_axi_arready, 1'b0);
      if (core_init === 1'b1) init_cnt++;
      if (core_next === 1'b1) next_cnt++;
    end
  end

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    core_result_valid = 1'b0;
    model_clear();
    @(posedge aclk); #1;
    repeat (n) begin
      @(negedge aclk);
      check("rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      check("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
      check("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 36'h0);
      check("rst_pulses", {core_init, core_next}, 2'b00);
      check("rst_key", core_key, 256'h0);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    logic [1:0] exp_resp;
    aw_done = 1'b0;
    w_done = 1'b0;
    c = 0;
    resp = 2'bxx;
    s_axi_awaddr = a;
    s_axi_wdata = d;
    s_axi_wstrb = s;
    while (!(aw_done && w_done)) begin
      s_axi_awvalid = !aw_done && (c >= aw_dly);
      s_axi_wvalid = !w_done && (c >= w_dly);
      @(negedge aclk);
      if (aw_done && !w_done) check("aw_held_blocks", s_axi_awready, 1'b0);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (aw_hs) aw_done = 1'b1;
      if (w_hs) w_done = 1'b1;
      c++;
      if (c > aw_dly + w_dly + 30) begin
        fail_now("aw_w_accept");
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        return;
      end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    c = 0;
    while (s_axi_bvalid !== 1'b1 && c < 20) begin
      @(posedge aclk); #1;
      c++;
    end
    if (s_axi_bvalid !== 1'b1) begin
      fail_now("bvalid");
      return;
    end
    check("commit_latency", c, 1);
    m_write(a, d, s, exp_resp);
    check("bresp", s_axi_bresp, exp_resp);
    resp = s_axi_bresp;
    repeat (b_dly) begin
      @(negedge aclk);
      check("bvalid_hold", s_axi_bvalid, 1'b1);
      @(posedge aclk); #1;
    end
    s_axi_bready = 1'b1;
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
    check("bvalid_clear", s_axi_bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [6:0] a, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit got;
    int c;
    got = 1'b0;
    c = 0;
    exp_d = '0;
    exp_r = '0;
    data = 'x;
    resp = 'x;
    repeat (ar_dly) begin @(posedge aclk); #1; end
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    while (!got) begin
      @(negedge aclk);
      if (s_axi_arready === 1'b1) begin
        got = 1'b1;
        m_read(a, exp_d, exp_r);
      end
      @(posedge aclk); #1;
      c++;
      if (!got && c > 20) begin
        fail_now("arready");
        s_axi_arvalid = 1'b0;
        return;
      end
    end
    s_axi_arvalid = 1'b0;
    check("rvalid_latency", s_axi_rvalid, 1'b1);
    check("rdata", s_axi_rdata, exp_d);
    check("rresp", s_axi_rresp, exp_r);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    repeat (r_dly) begin
      @(negedge aclk);
      check("rvalid_hold", s_axi_rvalid, 1'b1);
      check("rdata_hold", s_axi_rdata, exp_d);
      @(posedge aclk); #1;
    end
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
    check("rvalid_clear", s_axi_rvalid, 1'b0);
  endtask

  task automatic core_capture(input logic [127:0] res);
    core_result = res;
    core_result_valid = 1'b1;
    m_result[0] = res[127:96];
    m_result[1] = res[95:64];
    m_result[2] = res[63:32];
    m_result[3] = res[31:0];
    m_valid = 1'b1;
    repeat (2) begin @(posedge aclk); #1; end
    core_result_valid = 1'b0;
    @(posedge aclk); #1;
    core_result = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] kv [8];
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [1:0]  br;
    logic [6:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int op;

    kv[0] = 32'h2b7e1516; kv[1] = 32'h28aed2a6; kv[2] = 32'habf71588; kv[3] = 32'h09cf4f3c;
    kv[4] = 32'h0; kv[5] = 32'h0; kv[6] = 32'h0; kv[7] = 32'h0;

    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    core_ready = 1'b0; core_result = '0; core_result_valid = 1'b0;

    do_reset(3);

    axi_read(7'h04, 0, 0, rd, rr);
    check("reset_config", rd, 32'h0);
    axi_read(7'h08, 0, 0, rd, rr);
    check("reset_status", rd, 32'h0);

    core_ready = 1'b1;
    for (int i = 0; i < 8; i++) axi_write(7'(8'h18 + 4*i), kv[i], 4'hF, 0, 0, 0, br);
    for (int i = 0; i < 8; i++) begin
      axi_read(7'(8'h18 + 4*i), 0, i % 3, rd, rr);
      check("key_readback", rd, kv[i]);
      check("key_rresp", rr, 2'b00);
    end
    @(negedge aclk);
    check("core_key_hi", core_key[255:128], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(posedge aclk); #1;

    axi_write(7'h04, 32'h1, 4'hF, 0, 0, 0, br);
    init_cnt = 0; next_cnt = 0;
    axi_write(7'h00, 32'h1, 4'hF, 0, 0, 0, br);
    check("ctrl1_init_cnt", init_cnt, 1);
    check("ctrl1_next_cnt", next_cnt, 0);
    init_cnt = 0; next_cnt = 0;
    axi_write(7'h00, 32'h3, 4'hF, 0, 0, 2, br);
    check("ctrl3_init_cnt", init_cnt, 1);
    check("ctrl3_next_cnt", next_cnt, 0);

    core_ready = 1'b0;
    init_cnt = 0; next_cnt = 0;
    axi_write(7'h00, 32'h2, 4'hF, 0, 0, 0, br);
    check("drop_bresp", br, 2'b00);
    check("drop_pulses", init_cnt + next_cnt, 0);
    axi_read(7'h08, 0, 0, rd, rr);
    check("status_dropped", rd, 32'h4);
    axi_read(7'h08, 0, 0, rd, rr);
    check("status_cleared", rd, 32'h0);
    core_ready = 1'b1;

    axi_write(7'h3C, 32'hcafef00d, 4'hF, 0, 3, 5, br);
    axi_read(7'h3C, 0, 0, rd, rr);
    check("late_w_block1", rd, 32'hcafef00d);

    axi_write(7'h38, 32'h6bc1bee2, 4'b0011, 1, 0, 0, br);
    axi_read(7'h38, 0, 0, rd, rr);
    check("block0_strobe", rd, 32'h0000bee2);

    axi_write(7'h1C, 32'hffffffff, 4'b0000, 0, 0, 0, br);
    check("wstrb0_bresp", br, 2'b00);
    axi_read(7'h1C, 0, 0, rd, rr);
    check("wstrb0_key1", rd, 32'h28aed2a6);

    axi_write(7'h48, 32'hdeadbeef, 4'hF, 0, 0, 0, br);
    check("ro_write_bresp", br, 2'b10);
    axi_read(7'h10, 0, 0, rd, rr);
    check("unmapped_rresp", rr, 2'b10);
    check("unmapped_rdata", rd, 32'h0);
    axi_read(7'h48, 0, 0, rd, rr);
    check("result_unchanged", rd, 32'h0);

    core_capture(128'h874d6191b620e3261bef6864990db6ce);
    axi_read(7'h48, 0, 0, rd, rr); check("result0", rd, 32'h874d6191);
    axi_read(7'h4C, 0, 0, rd, rr); check("result1", rd, 32'hb620e326);
    axi_read(7'h50, 0, 0, rd, rr); check("result2", rd, 32'h1bef6864);
    axi_read(7'h54, 0, 0, rd, rr); check("result3", rd, 32'h990db6ce);
    axi_read(7'h08, 0, 0, rd, rr); check("status_valid", rd, 32'h3);
    init_cnt = 0; next_cnt = 0;
    axi_write(7'h00, 32'h2, 4'hF, 0, 0, 0, br);
    check("next_pulse_cnt", next_cnt, 1);
    axi_read(7'h08, 0, 0, rd, rr); check("status_valid_cleared", rd, 32'h1);
    axi_read(7'h48, 0, 0, rd, rr); check("result_kept", rd, 32'h874d6191);

    // Address accepted, then reset before data arrives: no response may appear.
    s_axi_awaddr = 7'h04;
    s_axi_awvalid = 1'b1;
    @(posedge aclk); #1;
    s_axi_awvalid = 1'b0;
    do_reset(2);
    repeat (4) begin
      @(negedge aclk);
      check("no_b_after_reset", s_axi_bvalid, 1'b0);
      check("aw_free_after_reset", s_axi_awready, 1'b1);
    end
    @(posedge aclk); #1;
    axi_read(7'h18, 0, 0, rd, rr);
    check("key0_after_reset", rd, 32'h0);

    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      core_ready = ($urandom_range(0, 3) != 0);
      a = {5'($urandom_range(0, 23)), 2'($urandom)};
      if (op == 0) begin
        core_capture({$urandom, $urandom, $urandom, $urandom});
      end else if (op < 6) begin
        d = $urandom;
        s = 4'($urandom);
        if (a[6:2] == 5'd0) s = 4'hF;
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br);
      end else begin
        axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3), rd, rr);
      end
    end

    repeat (3) @(posedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
